// File: rtl/dm_pkg.sv
// Shared constants for the data_memory block: default geometry and lane-enable encodings.
package dm_pkg;

   localparam int DM_DATA_W = 32;
   localparam int DM_ADDR_W = 6;
   localparam int DM_DEPTH  = 64;

   // Lane enables: bit0 selects the low half-word, bit1 the high half-word.
   localparam logic [1:0] DM_SEL_NONE = 2'b00;
   localparam logic [1:0] DM_SEL_LO   = 2'b01;
   localparam logic [1:0] DM_SEL_HI   = 2'b10;
   localparam logic [1:0] DM_SEL_WORD = 2'b11;

endpackage

// File: rtl/data_memory_if.sv
// Access/display bus of data_memory.
// Handshake: there is no valid/ready pair. A store is requested by holding str=1
// with addr/din/sel stable across a rising clk edge; both read ports are
// combinational and always valid (zero latency).
interface data_memory_if
   import dm_pkg::*;
#(
   parameter int DATA_W = DM_DATA_W,
   parameter int ADDR_W = DM_ADDR_W
);

   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] din;
   logic              str;
   logic [1:0]        sel;
   logic [DATA_W-1:0] dout;
   logic [DATA_W-1:0] disp_dout;

   // CPU side / testbench drives requests and observes read data.
   modport master (
      output addr, disp_addr, din, str, sel,
      input  dout, disp_dout
   );

   // Memory side.
   modport slave (
      input  addr, disp_addr, din, str, sel,
      output dout, disp_dout
   );

endinterface

// File: rtl/dm_lane_merge.sv
// Half-word lane merge: selected lanes come from din, the rest from the old word.
// Shared by the write path and the optional same-cycle bypass path.
module dm_lane_merge
   import dm_pkg::*;
#(
   parameter int DATA_W = DM_DATA_W
) (
   input  logic [DATA_W-1:0] i_old,
   input  logic [DATA_W-1:0] i_din,
   input  logic [1:0]        i_sel,
   output logic [DATA_W-1:0] o_merged
);

   localparam int HALF_W = DATA_W / 2;

   logic w_lo_en;
   logic w_hi_en;

   assign w_lo_en = ((i_sel & DM_SEL_LO) != DM_SEL_NONE);
   assign w_hi_en = ((i_sel & DM_SEL_HI) != DM_SEL_NONE);

   // Start from the old word and overwrite only the enabled half-words.
   always_comb begin
      o_merged = i_old;
      if (w_lo_en) begin
         o_merged[HALF_W-1:0] = i_din[HALF_W-1:0];
      end
      if (w_hi_en) begin
         o_merged[DATA_W-1:HALF_W] = i_din[DATA_W-1:HALF_W];
      end
   end

endmodule

// File: rtl/data_memory.sv
// data_memory: word-addressed register-array memory for the MEM stage.
// One synchronous write port with half-word lane enables, two independent
// combinational read ports (access and display). Contents clear on async reset.
// Optional macro DM_WRITE_BYPASS_EN: forward the merged store word to the read
// ports in the same cycle as the store.
// DATA_W must be even (two half-word lanes).
module data_memory
   import dm_pkg::*;
#(
   parameter int DATA_W = DM_DATA_W,
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input logic         clk,
   input logic         rst,
   data_memory_if.slave bus
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_merged;
   logic              w_we;

   assign w_old = r_mem[bus.addr];
   // sel=00 would rewrite the old word unchanged; skip it entirely.
   assign w_we  = bus.str && (bus.sel != DM_SEL_NONE);

   dm_lane_merge #(
      .DATA_W (DATA_W)
   ) u_lane_merge (
      .i_old    (w_old),
      .i_din    (bus.din),
      .i_sel    (bus.sel),
      .o_merged (w_merged)
   );

   // Storage: async clear of every word, lane-merged store on the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_we) begin
         r_mem[bus.addr] <= w_merged;
      end
   end

   // Read ports: forced to zero during reset, otherwise plain array reads
   // (plus same-cycle forwarding of the store word when bypass is built in).
   always_comb begin
      bus.dout      = '0;
      bus.disp_dout = '0;
      if (!rst) begin
`ifdef DM_WRITE_BYPASS_EN
         if (bus.str) begin
            bus.dout = w_merged;
         end else begin
            bus.dout = r_mem[bus.addr];
         end
         if (bus.str && (bus.disp_addr == bus.addr)) begin
            bus.disp_dout = w_merged;
         end else begin
            bus.disp_dout = r_mem[bus.disp_addr];
         end
`else
         bus.dout      = r_mem[bus.addr];
         bus.disp_dout = r_mem[bus.disp_addr];
`endif
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory.
module tb_data_memory;
   import dm_pkg::*;

   localparam int DW = DM_DATA_W;
   localparam int AW = DM_ADDR_W;

   typedef struct {
      logic          str;
      logic [1:0]    sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic [DW-1:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;
   vec_t vecs [10];

   data_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   data_memory #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Clock: 10 time-unit period, rising edges at 5, 15, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drive one store request at the falling edge, let one rising edge pass.
   task automatic store_cycle(input logic str, input logic [1:0] sel,
                              input logic [AW-1:0] addr, input logic [DW-1:0] din);
      @(negedge clk);
      bus.str       = str;
      bus.sel       = sel;
      bus.addr      = addr;
      bus.disp_addr = addr;
      bus.din       = din;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] pre_exp;
      logic          all_zero;

      n_total = 0;
      n_pass  = 0;

      vecs[0] = '{1'b1, DM_SEL_WORD, 6'd3,  32'h1234_5678, 32'h1234_5678};
      vecs[1] = '{1'b1, DM_SEL_LO,   6'd3,  32'hAAAA_BBBB, 32'h1234_BBBB};
      vecs[2] = '{1'b1, DM_SEL_HI,   6'd3,  32'hCCCC_DDDD, 32'hCCCC_BBBB};
      vecs[3] = '{1'b1, DM_SEL_NONE, 6'd3,  32'h9999_9999, 32'hCCCC_BBBB};
      vecs[4] = '{1'b0, DM_SEL_WORD, 6'd3,  32'hFFFF_FFFF, 32'hCCCC_BBBB};
      vecs[5] = '{1'b0, DM_SEL_WORD, 6'd3,  32'hFFFF_FFFF, 32'hCCCC_BBBB};
      vecs[6] = '{1'b0, DM_SEL_WORD, 6'd3,  32'hFFFF_FFFF, 32'hCCCC_BBBB};
      vecs[7] = '{1'b1, DM_SEL_WORD, 6'd0,  32'h0000_0001, 32'h0000_0001};
      vecs[8] = '{1'b1, DM_SEL_WORD, 6'd63, 32'h0000_003F, 32'h0000_003F};
      vecs[9] = '{1'b1, DM_SEL_WORD, 6'd7,  32'h0000_0011, 32'h0000_0011};

      // Power-on reset with a store request pending: must be ignored.
      rst           = 1'b1;
      bus.str       = 1'b1;
      bus.sel       = DM_SEL_WORD;
      bus.addr      = 6'd5;
      bus.disp_addr = 6'd5;
      bus.din       = 32'h5555_5555;
      repeat (2) @(posedge clk);
      #1;
      check("reset_dout", bus.dout, 32'h0);
      check("reset_disp", bus.disp_dout, 32'h0);

      // Deassert mid-cycle with the store still held: no write before next edge.
      @(negedge clk);
      bus.addr      = 6'd10;
      bus.disp_addr = 6'd9;
      bus.str       = 1'b0;
      bus.din       = 32'h0000_0055;
      #1;
      bus.addr = 6'd9;
      bus.str  = 1'b1;
      bus.addr = 6'd10;
      rst      = 1'b0;
      #1;
      bus.addr = 6'd9;
      bus.disp_addr = 6'd10;
      bus.str  = 1'b0;
      #1;
      check("rst_release_no_write", bus.dout, 32'h0);
      bus.str = 1'b1;
      @(posedge clk);
      #1;
      bus.str = 1'b0;
      check("first_write_after_rst", bus.dout, 32'h0000_0055);

      // Async clear without a clock edge.
      store_cycle(1'b1, DM_SEL_WORD, 6'd5, 32'hDEAD_BEEF);
      bus.str = 1'b0;
      check("deadbeef_written", bus.dout, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_clear_dout", bus.dout, 32'h0);
      #1;
      rst = 1'b0;
      all_zero = 1'b1;
      for (int a = 0; a < DM_DEPTH; a++) begin
         bus.addr      = AW'(a);
         bus.disp_addr = AW'(DM_DEPTH - 1 - a);
         #1;
         if (bus.dout !== 32'h0 || bus.disp_dout !== 32'h0) all_zero = 1'b0;
         if (a == 0) check("clear_addr0", bus.dout, 32'h0);
      end
      check("clear_all_words", {31'h0, all_zero}, 32'h1);

      // Table-driven store/read vectors.
      for (int i = 0; i < 10; i++) begin
         store_cycle(vecs[i].str, vecs[i].sel, vecs[i].addr, vecs[i].din);
         bus.str = 1'b0;
         check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp);
         check($sformatf("vec%0d_disp", i), bus.disp_dout, vecs[i].exp);
      end

      // Independent dual read at the address boundaries.
      @(negedge clk);
      bus.addr      = 6'd0;
      bus.disp_addr = 6'd63;
      #1;
      check("dual_dout_addr0", bus.dout, 32'h0000_0001);
      check("dual_disp_addr63", bus.disp_dout, 32'h0000_003F);
      bus.addr      = 6'd3;
      bus.disp_addr = 6'd3;
      #1;
      check("same_addr_dout", bus.dout, 32'hCCCC_BBBB);
      check("same_addr_disp", bus.disp_dout, 32'hCCCC_BBBB);

      // Read-during-write at addr 7 (holds 0x11).
`ifdef DM_WRITE_BYPASS_EN
      pre_exp = 32'h0000_0022;
`else
      pre_exp = 32'h0000_0011;
`endif
      @(negedge clk);
      bus.addr      = 6'd7;
      bus.disp_addr = 6'd7;
      bus.sel       = DM_SEL_WORD;
      bus.din       = 32'h0000_0022;
      bus.str       = 1'b1;
      #1;
      check("rdw_before_edge", bus.dout, pre_exp);
      check("rdw_disp_before_edge", bus.disp_dout, pre_exp);
      @(posedge clk);
      #1;
      bus.str = 1'b0;
      check("rdw_after_edge", bus.dout, 32'h0000_0022);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
